// File: rtl/peripheral_spram_arbiter.sv
// -----------------------------------------------------------------------------
// PeripheralSpramArbiter
//
// Purpose:
//   Two-requester arbiter in front of a single-port SRAM. It accepts at most
//   one access per cycle. Grants are combinational, so a request is accepted
//   in the same cycle it is presented. When both requesters ask at once, the
//   one that was not granted most recently wins. A requester can lock the
//   memory for a sequence of accesses. While the lock is held, only the lock
//   owner can be granted. The read response returns one cycle after the
//   grant and goes only to the requester that issued the read.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge) and asynchronous active-low reset
//   mN_req_i   (N=0,1)     access request
//   mN_we_i                1 = write, 0 = read
//   mN_lock_i              keep the grant for this requester's next access
//   mN_addr_i              access address
//   mN_be_i                write byte enables
//   mN_data_i              write data
//   mN_gnt_o               access accepted this cycle
//   mN_rvalid_o            read data valid (one cycle after a read grant)
//   mN_rdata_o             read data (mirrors mem_data_i, qualified by rvalid)
//   mem_req_o, mem_we_o    SRAM request and write enable
//   mem_addr_o             SRAM address
//   mem_be_o               SRAM byte enables
//   mem_data_o             SRAM write data
//   mem_data_i             SRAM read data, valid the cycle after a read request
// -----------------------------------------------------------------------------
module peripheral_spram_arbiter #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,

   input  logic                        m0_req_i,
   input  logic                        m0_we_i,
   input  logic                        m0_lock_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [AXI_DATA_WIDTH-1:0]   m0_data_i,
   output logic                        m0_gnt_o,
   output logic                        m0_rvalid_o,
   output logic [AXI_DATA_WIDTH-1:0]   m0_rdata_o,

   input  logic                        m1_req_i,
   input  logic                        m1_we_i,
   input  logic                        m1_lock_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [AXI_DATA_WIDTH-1:0]   m1_data_i,
   output logic                        m1_gnt_o,
   output logic                        m1_rvalid_o,
   output logic [AXI_DATA_WIDTH-1:0]   m1_rdata_o,

   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
   output logic [AXI_DATA_WIDTH-1:0]   mem_data_o,
   input  logic [AXI_DATA_WIDTH-1:0]   mem_data_i
);

   // Lock ownership. LOCK_NONE means normal alternating arbitration.
   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_M0   = 2'd1,
      LOCK_M1   = 2'd2
   } lock_state_e;

   lock_state_e lock_state;
   lock_state_e lock_next;

   // Index of the requester granted most recently (0 or 1).
   logic last_q;

   logic rvalid0_q;
   logic rvalid1_q;

   logic gnt0;
   logic gnt1;

   // State register for the lock FSM. Reset leaves the memory unlocked.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_state <= LOCK_NONE;
      end else begin
         lock_state <= lock_next;
      end
   end

   // Lock next-state logic.
   // A granted access decides the lock on its own. With lock=1, the granted
   // requester becomes (or stays) the owner. With lock=0, the memory is
   // unlocked afterwards. This covers two cases: the owner releasing the lock
   // on its final access, and an ordinary unlocked access.
   // With no grant, the lock is unchanged.
   always_comb begin
      lock_next = lock_state;
      if (gnt0) begin
         lock_next = m0_lock_i ? LOCK_M0 : LOCK_NONE;
      end else if (gnt1) begin
         lock_next = m1_lock_i ? LOCK_M1 : LOCK_NONE;
      end
   end

   // Grant logic (FSM output process).
   // When locked, only the owner can be granted, and an idle owner leaves the
   // memory unused. When unlocked and both requesters are active, the one not
   // granted last time wins. Both grants are forced low while reset is
   // asserted, because they are combinational and would otherwise follow the
   // requests during reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (lock_state)
         LOCK_M0: begin
            gnt0 = m0_req_i;
         end
         LOCK_M1: begin
            gnt1 = m1_req_i;
         end
         default: begin
            if (m0_req_i && m1_req_i) begin
               gnt0 = last_q;
               gnt1 = ~last_q;
            end else begin
               gnt0 = m0_req_i;
               gnt1 = m1_req_i;
            end
         end
      endcase
      if (!rst_ni) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign m0_gnt_o = gnt0;
   assign m1_gnt_o = gnt1;

   // Record the winner of every grant. Resetting to 1 lets m0 win the first
   // contention after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else if (gnt0) begin
         last_q <= 1'b0;
      end else if (gnt1) begin
         last_q <= 1'b1;
      end
   end

   // Remember which requester issued a read, so the SRAM response one cycle
   // later goes to it alone. Reset clears these flags, which cancels any
   // read response still pending.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= gnt0 & ~m0_we_i;
         rvalid1_q <= gnt1 & ~m1_we_i;
      end
   end

   assign m0_rvalid_o = rvalid0_q;
   assign m1_rvalid_o = rvalid1_q;

   // The SRAM read bus goes to both requesters. The rvalid flags decide who
   // actually uses it.
   assign m0_rdata_o = mem_data_i;
   assign m1_rdata_o = mem_data_i;

   // SRAM command mux. The granted requester's fields pass through
   // unmodified. With no grant, every field is driven to zero.
   always_comb begin
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = '0;
      mem_be_o   = '0;
      mem_data_o = '0;
      if (gnt0) begin
         mem_req_o  = 1'b1;
         mem_we_o   = m0_we_i;
         mem_addr_o = m0_addr_i;
         mem_be_o   = m0_be_i;
         mem_data_o = m0_data_i;
      end else if (gnt1) begin
         mem_req_o  = 1'b1;
         mem_we_o   = m1_we_i;
         mem_addr_o = m1_addr_i;
         mem_be_o   = m1_be_i;
         mem_data_o = m1_data_i;
      end
   end

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
// -----------------------------------------------------------------------------
// TbPeripheralSpramArbiter
//
// Self-checking bench for peripheral_spram_arbiter. A behavioural model keeps
// the lock owner, the last winner, the pending read responses and a small
// SRAM image. It also drives mem_data_i. One compare process checks every
// DUT output against the model on each falling clock edge. Directed
// scenarios add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_peripheral_spram_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;

   logic        m0_req, m0_we, m0_lock;
   logic [63:0] m0_addr, m0_data;
   logic [7:0]  m0_be;
   logic        m0_gnt, m0_rvalid;
   logic [63:0] m0_rdata;

   logic        m1_req, m1_we, m1_lock;
   logic [63:0] m1_addr, m1_data;
   logic [7:0]  m1_be;
   logic        m1_gnt, m1_rvalid;
   logic [63:0] m1_rdata;

   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_be;
   logic [63:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   // Model state: owner -1 means unlocked.
   int          owner = -1;
   int          last  = 1;
   bit          pend0 = 1'b0;
   bit          pend1 = 1'b0;
   logic [63:0] sram [16];

   always #5 clk_i = ~clk_i;

   peripheral_spram_arbiter #(
      .AXI_ADDR_WIDTH(64),
      .AXI_DATA_WIDTH(64)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .m0_req_i    (m0_req),
      .m0_we_i     (m0_we),
      .m0_lock_i   (m0_lock),
      .m0_addr_i   (m0_addr),
      .m0_be_i     (m0_be),
      .m0_data_i   (m0_data),
      .m0_gnt_o    (m0_gnt),
      .m0_rvalid_o (m0_rvalid),
      .m0_rdata_o  (m0_rdata),
      .m1_req_i    (m1_req),
      .m1_we_i     (m1_we),
      .m1_lock_i   (m1_lock),
      .m1_addr_i   (m1_addr),
      .m1_be_i     (m1_be),
      .m1_data_i   (m1_data),
      .m1_gnt_o    (m1_gnt),
      .m1_rvalid_o (m1_rvalid),
      .m1_rdata_o  (m1_rdata),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_be_o    (mem_be),
      .mem_data_o  (mem_wdata),
      .mem_data_i  (mem_rdata)
   );

   // Which requester should be granted right now (-1 for none), based only
   // on the current inputs and the model's lock owner and last winner.
   function automatic int expectGrant();
      if (rst_ni !== 1'b1) return -1;
      if (owner == 0) return m0_req ? 0 : -1;
      if (owner == 1) return m1_req ? 1 : -1;
      if (m0_req && m1_req) return (last == 0) ? 1 : 0;
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(
      input logic r0, input logic w0, input logic l0, input logic [63:0] a0,
      input logic [7:0] b0, input logic [63:0] d0,
      input logic r1, input logic w1, input logic l1, input logic [63:0] a1,
      input logic [7:0] b1, input logic [63:0] d1);
      @(negedge clk_i);
      m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_be = b0; m0_data = d0;
      m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_be = b1; m1_data = d1;
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 64'h0, 8'h0, 64'h0, 0, 0, 0, 64'h0, 8'h0, 64'h0);
   endtask

   // Model update. An accepted access moves the lock and the last winner,
   // updates the SRAM image on a write, and on a read schedules the response
   // and presents the SRAM word on mem_data_i. Otherwise mem_data_i carries
   // junk, which the DUT must still pass through on rdata.
   always @(posedge clk_i or negedge rst_ni) begin : model_update
      int          g;
      logic        we, lk;
      logic [63:0] a, d;
      logic [7:0]  b;
      if (!rst_ni) begin
         owner = -1;
         last  = 1;
         pend0 = 1'b0;
         pend1 = 1'b0;
      end else begin
         g = expectGrant();
         pend0 = 1'b0;
         pend1 = 1'b0;
         mem_rdata = {$urandom, $urandom};
         if (g >= 0) begin
            we = (g == 0) ? m0_we   : m1_we;
            lk = (g == 0) ? m0_lock : m1_lock;
            a  = (g == 0) ? m0_addr : m1_addr;
            d  = (g == 0) ? m0_data : m1_data;
            b  = (g == 0) ? m0_be   : m1_be;
            last  = g;
            owner = lk ? g : -1;
            if (we) begin
               for (int i = 0; i < 8; i++)
                  if (b[i]) sram[a[3:0]][i*8 +: 8] = d[i*8 +: 8];
            end else begin
               mem_rdata = sram[a[3:0]];
               if (g == 0) pend0 = 1'b1;
               else        pend1 = 1'b1;
            end
         end
      end
   end

   // Every cycle: compare all DUT outputs against the model.
   always @(negedge clk_i) begin : compare_proc
      int          g;
      logic        e_we;
      logic [63:0] e_addr, e_data;
      logic [7:0]  e_be;
      #2;
      g = expectGrant();
      e_we = 1'b0; e_addr = '0; e_data = '0; e_be = '0;
      if (g == 0) begin
         e_we = m0_we; e_addr = m0_addr; e_data = m0_data; e_be = m0_be;
      end else if (g == 1) begin
         e_we = m1_we; e_addr = m1_addr; e_data = m1_data; e_be = m1_be;
      end
      checkOutput("m0_gnt",    64'(m0_gnt),    64'(g == 0));
      checkOutput("m1_gnt",    64'(m1_gnt),    64'(g == 1));
      checkOutput("mem_req",   64'(mem_req),   64'(g >= 0));
      checkOutput("mem_we",    64'(mem_we),    64'(e_we));
      checkOutput("mem_addr",  mem_addr,       e_addr);
      checkOutput("mem_be",    64'(mem_be),    64'(e_be));
      checkOutput("mem_data",  mem_wdata,      e_data);
      checkOutput("m0_rvalid", 64'(m0_rvalid), 64'(pend0));
      checkOutput("m1_rvalid", 64'(m1_rvalid), 64'(pend1));
      checkOutput("m0_rdata",  m0_rdata,       mem_rdata);
      checkOutput("m1_rdata",  m1_rdata,       mem_rdata);
   end

   initial begin
      rst_ni = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 16; i++) sram[i] = '0;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_be = '0; m0_data = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_be = '0; m1_data = '0;

      // Requests during reset must not be granted.
      applyStimulus(1, 1, 0, 64'h10, 8'hFF, 64'h1, 1, 1, 0, 64'h20, 8'hFF, 64'h2);
      #3;
      checkOutput("rst_m0_gnt",  64'(m0_gnt),  64'd0);
      checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
      applyIdle();
      rst_ni = 1'b1;

      // m0 write: granted and forwarded in the same cycle.
      applyStimulus(1, 1, 0, 64'h10, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0, 0, 0, 64'h0, 8'h0, 64'h0);
      #3;
      checkOutput("wr_gnt0",     64'(m0_gnt),  64'd1);
      checkOutput("wr_mem_req",  64'(mem_req), 64'd1);
      checkOutput("wr_mem_we",   64'(mem_we),  64'd1);
      checkOutput("wr_mem_addr", mem_addr,     64'h10);

      // m0 read of the same word. The write leaves no rvalid behind.
      applyStimulus(1, 0, 0, 64'h10, 8'hFF, 64'h0, 0, 0, 0, 64'h0, 8'h0, 64'h0);
      #3;
      checkOutput("wr_no_rvalid", 64'(m0_rvalid), 64'd0);
      checkOutput("rd_gnt0",      64'(m0_gnt),    64'd1);
      applyIdle();
      #3;
      checkOutput("rd_rvalid0", 64'(m0_rvalid), 64'd1);
      checkOutput("rd_rdata0",  m0_rdata,       64'hA5A5A5A5A5A5A5A5);
      checkOutput("rd_rvalid1", 64'(m1_rvalid), 64'd0);

      // Fresh reset, then both requesters contend for 4 cycles.
      applyIdle();
      rst_ni = 1'b0;
      applyIdle();
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 0, 64'h0, 8'h01, 64'h0, 1, 1, 0, 64'h8, 8'h01, 64'h0);
         #3;
         checkOutput("rr_gnt0", 64'(m0_gnt), 64'(i % 2 == 0));
         checkOutput("rr_gnt1", 64'(m1_gnt), 64'(i % 2 == 1));
      end

      // m1 locks for three accesses while m0 keeps requesting.
      applyStimulus(1, 1, 0, 64'h0, 8'h01, 64'h0, 0, 0, 0, 64'h0, 8'h0, 64'h0);
      #3;
      checkOutput("pre_lock_gnt0", 64'(m0_gnt), 64'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 64'h0, 8'h01, 64'h0, 1, 1, (i < 2), 64'h8, 8'h01, 64'h0);
         #3;
         checkOutput("lock_gnt1", 64'(m1_gnt), 64'd1);
      end
      applyStimulus(1, 1, 0, 64'h0, 8'h01, 64'h0, 1, 1, 0, 64'h8, 8'h01, 64'h0);
      #3;
      checkOutput("unlock_gnt0", 64'(m0_gnt), 64'd1);

      // m0 takes the lock and then goes idle. m1 must be blocked.
      applyStimulus(1, 1, 1, 64'h0, 8'h01, 64'h0, 0, 0, 0, 64'h0, 8'h0, 64'h0);
      #3;
      checkOutput("own0_gnt0", 64'(m0_gnt), 64'd1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 64'h0, 8'h0, 64'h0, 1, 1, 0, 64'h8, 8'h01, 64'h0);
         #3;
         checkOutput("idle_owner_gnt1", 64'(m1_gnt),  64'd0);
         checkOutput("idle_owner_req",  64'(mem_req), 64'd0);
      end
      applyStimulus(1, 1, 0, 64'h0, 8'h01, 64'h0, 1, 1, 0, 64'h8, 8'h01, 64'h0);
      #3;
      checkOutput("release_gnt0", 64'(m0_gnt), 64'd1);
      applyStimulus(0, 0, 0, 64'h0, 8'h0, 64'h0, 1, 1, 0, 64'h8, 8'h01, 64'h0);
      #3;
      checkOutput("after_release_gnt1", 64'(m1_gnt), 64'd1);

      // Reset between an m1 read grant and its response.
      applyStimulus(0, 0, 0, 64'h0, 8'h0, 64'h0, 1, 0, 0, 64'h10, 8'hFF, 64'h0);
      #3;
      checkOutput("cancel_gnt1", 64'(m1_gnt), 64'd1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      m1_req = 1'b0;
      @(negedge clk_i);
      #3;
      checkOutput("cancel_rvalid1", 64'(m1_rvalid), 64'd0);
      rst_ni = 1'b1;
      applyIdle();
      #3;
      checkOutput("post_rst_rvalid1", 64'(m1_rvalid), 64'd0);
      applyStimulus(1, 1, 0, 64'h0, 8'h01, 64'h0, 1, 1, 0, 64'h8, 8'h01, 64'h0);
      #3;
      checkOutput("post_rst_gnt0", 64'(m0_gnt), 64'd1);

      // Randomized traffic, with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
                       64'($urandom_range(0, 255)), 8'($urandom), {$urandom, $urandom},
                       $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
                       64'($urandom_range(0, 255)), 8'($urandom), {$urandom, $urandom});
         rst_ni = ($urandom_range(0, 199) != 0);
      end
      applyIdle();
      rst_ni = 1'b1;
      applyIdle();
      #3;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
